// File: rtl/pixel_ctrl_pkg.sv
// Shared types, default timing and helpers for the pixel array frame sequencer.
package pixel_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StErase,
        StExpose,
        StConvert,
        StRead
    } pixel_state_t;

    localparam int unsigned DefEraseCycles  = 5;
    localparam int unsigned DefExposeCycles = 10;
    localparam int unsigned DefCounterWidth = 8;
    localparam int unsigned DefNumRows      = 2;

    // Binary to reflected Gray code; callers truncate to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/pixel_ramp_counter.sv
// Conversion ramp counter: sync clear, enable, registered output.
// Build option GRAY_COUNTER_EN selects a Gray-coded output instead of binary.
module pixel_ramp_counter
    import pixel_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefCounterWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] code_d;

    // Next binary value and its encoded form; the code is registered so pixels never see XOR glitches.
    always_comb begin
        bin_d = bin_q;
        if (clr) begin
            bin_d = '0;
        end else if (en) begin
            bin_d = bin_q + 1'b1;
        end
`ifdef GRAY_COUNTER_EN
        code_d = WIDTH'(bin2gray(32'(bin_d)));
`else
        code_d = bin_d;
`endif
    end

    // Counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
            count <= '0;
        end else begin
            bin_q <= bin_d;
            count <= code_d;
        end
    end

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the pixel array: erase -> expose -> convert -> read-out.
// Build option GRAY_COUNTER_EN makes the conversion counter Gray-coded.
module pixel_array_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int unsigned ERASE_CYCLES  = DefEraseCycles,
    parameter int unsigned EXPOSE_CYCLES = DefExposeCycles,
    parameter int unsigned COUNTER_WIDTH = DefCounterWidth,
    parameter int unsigned NUM_ROWS      = DefNumRows
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    output logic                     power_enable,
    output logic                     pixel_erase,
    output logic                     expose,
    output logic                     write_enable,
    output logic                     counter_reset,
    output logic [COUNTER_WIDTH-1:0] counter,
    output logic [NUM_ROWS-1:0]      read_row,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int unsigned ConvertCycles = 1 << COUNTER_WIDTH;
    localparam int unsigned MaxA = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
    localparam int unsigned MaxB = (ConvertCycles > NUM_ROWS) ? ConvertCycles : NUM_ROWS;
    localparam int unsigned MaxCycles = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned TimerW = $clog2(MaxCycles + 1);

    localparam logic [TimerW-1:0] EraseLast   = TimerW'(ERASE_CYCLES - 1);
    localparam logic [TimerW-1:0] ExposeLast  = TimerW'(EXPOSE_CYCLES - 1);
    localparam logic [TimerW-1:0] ConvertLast = TimerW'(ConvertCycles - 1);
    localparam logic [TimerW-1:0] ReadLast    = TimerW'(NUM_ROWS - 1);

    pixel_state_t      state_q;
    logic [TimerW-1:0] timer_q;
    logic              ramp_clr;
    logic              ramp_en;

    // Ramp tracks the timer inside CONVERT; it is zero on entry and cleared on any exit.
    assign ramp_clr = abort || (state_q != StConvert) || (timer_q == ConvertLast);
    assign ramp_en  = (state_q == StConvert);

    pixel_ramp_counter #(
        .WIDTH(COUNTER_WIDTH)
    ) u_ramp (
        .clk  (clk),
        .rst  (rst),
        .clr  (ramp_clr),
        .en   (ramp_en),
        .count(counter)
    );

    // Frame FSM; outputs are written for the state being entered so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            power_enable  <= 1'b0;
            pixel_erase   <= 1'b0;
            expose        <= 1'b0;
            write_enable  <= 1'b0;
            counter_reset <= 1'b0;
            read_row      <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            power_enable  <= 1'b0;
            pixel_erase   <= 1'b0;
            expose        <= 1'b0;
            write_enable  <= 1'b0;
            counter_reset <= 1'b0;
            read_row      <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            timer_q       <= timer_q + 1'b1;
            if (abort) begin
                state_q <= StIdle;
                timer_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        timer_q <= '0;
                        if (start) begin
                            state_q      <= StErase;
                            power_enable <= 1'b1;
                            pixel_erase  <= 1'b1;
                            busy         <= 1'b1;
                        end
                    end
                    StErase: begin
                        power_enable <= 1'b1;
                        busy         <= 1'b1;
                        if (timer_q == EraseLast) begin
                            state_q <= StExpose;
                            timer_q <= '0;
                            expose  <= 1'b1;
                        end else begin
                            pixel_erase <= 1'b1;
                        end
                    end
                    StExpose: begin
                        power_enable <= 1'b1;
                        busy         <= 1'b1;
                        if (timer_q == ExposeLast) begin
                            state_q       <= StConvert;
                            timer_q       <= '0;
                            write_enable  <= 1'b1;
                            counter_reset <= 1'b1;
                        end else begin
                            expose <= 1'b1;
                        end
                    end
                    StConvert: begin
                        busy <= 1'b1;
                        if (timer_q == ConvertLast) begin
                            state_q  <= StRead;
                            timer_q  <= '0;
                            read_row <= NUM_ROWS'(1);
                        end else begin
                            power_enable <= 1'b1;
                            write_enable <= 1'b1;
                        end
                    end
                    StRead: begin
                        if (timer_q == ReadLast) begin
                            state_q    <= StIdle;
                            timer_q    <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            busy     <= 1'b1;
                            read_row <= NUM_ROWS'(1) << (timer_q + 1'b1);
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        timer_q <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Self-checking bench for pixel_array_ctrl at default parameters.
// Honours GRAY_COUNTER_EN when the same define is given to the build.
module tb_pixel_array_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       power_enable;
    logic       pixel_erase;
    logic       expose;
    logic       write_enable;
    logic       counter_reset;
    logic [7:0] counter;
    logic [1:0] read_row;
    logic       busy;
    logic       frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    pixel_array_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .power_enable (power_enable),
        .pixel_erase  (pixel_erase),
        .expose       (expose),
        .write_enable (write_enable),
        .counter_reset(counter_reset),
        .counter      (counter),
        .read_row     (read_row),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Expected control bits packed as {pe, erase, expose, we, ctr_reset, busy, frame_done}.
    typedef struct {
        int         k;
        logic [6:0] ctl;
        int         cnt;
        logic [1:0] row;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [6:0] ctl_now();
        return {power_enable, pixel_erase, expose, write_enable, counter_reset, busy, frame_done};
    endfunction

    function automatic logic [7:0] code(input int b);
        logic [7:0] v;
        v = 8'(b);
`ifdef GRAY_COUNTER_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles after a START edge; k counts edges after the one that sampled START.
    task automatic run_frame(input int pulse_at, input int n, output int busy_cnt, output int fd_cnt);
        logic [7:0] prev;
        int         bad_ramp;
        int         bad_step;
        busy_cnt = 0;
        fd_cnt   = 0;
        bad_ramp = 0;
        bad_step = 0;
        prev     = '0;
        for (int k = 0; k < n; k++) begin
            step();
            start = (k == pulse_at);
            busy_cnt += int'(busy);
            fd_cnt   += int'(frame_done);
            for (int i = 0; i < 12; i++) begin
                if (tbl[i].k == k) begin
                    chk($sformatf("ctl@%0d", k), 32'(ctl_now()), 32'(tbl[i].ctl));
                    chk($sformatf("cnt@%0d", k), 32'(counter), 32'(code(tbl[i].cnt)));
                    chk($sformatf("row@%0d", k), 32'(read_row), 32'(tbl[i].row));
                end
            end
            if (k >= 15 && k <= 270) begin
                if (counter !== code(k - 15)) bad_ramp++;
                if (k >= 16 && $countones(counter ^ prev) != 1) bad_step++;
                prev = counter;
            end
        end
        chk("ramp_sequence_errors", 32'(bad_ramp), 32'd0);
`ifdef GRAY_COUNTER_EN
        chk("gray_multi_bit_steps", 32'(bad_step), 32'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int f;
        logic [599:0] bz;
        logic [599:0] fd;

        tbl[0]  = '{0,   7'b1100010, 0,   2'b00};
        tbl[1]  = '{4,   7'b1100010, 0,   2'b00};
        tbl[2]  = '{5,   7'b1010010, 0,   2'b00};
        tbl[3]  = '{14,  7'b1010010, 0,   2'b00};
        tbl[4]  = '{15,  7'b1001110, 0,   2'b00};
        tbl[5]  = '{16,  7'b1001010, 1,   2'b00};
        tbl[6]  = '{52,  7'b1001010, 37,  2'b00};
        tbl[7]  = '{270, 7'b1001010, 255, 2'b00};
        tbl[8]  = '{271, 7'b0000010, 0,   2'b01};
        tbl[9]  = '{272, 7'b0000010, 0,   2'b10};
        tbl[10] = '{273, 7'b0000001, 0,   2'b00};
        tbl[11] = '{274, 7'b0000000, 0,   2'b00};

        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_ctl", 32'(ctl_now()), 32'd0);
        chk("reset_cnt", 32'(counter), 32'd0);
        chk("reset_row", 32'(read_row), 32'd0);

        // Normal frame from a one-cycle START pulse.
        start = 1'b1;
        run_frame(-1, 280, b, f);
        chk("frame_busy_cycles", 32'(b), 32'd273);
        chk("frame_done_count", 32'(f), 32'd1);

        // START during EXPOSE is ignored.
        start = 1'b1;
        run_frame(8, 300, b, f);
        chk("busy_start_busy_cycles", 32'(b), 32'd273);
        chk("busy_start_done_count", 32'(f), 32'd1);

        // Async reset mid-CONVERT with counter at 37.
        start = 1'b1;
        for (int k = 0; k <= 52; k++) begin
            step();
            start = 1'b0;
        end
        chk("pre_reset_cnt", 32'(counter), 32'(code(37)));
        #2 rst = 1'b1;
        #1;
        chk("async_reset_ctl", 32'(ctl_now()), 32'd0);
        chk("async_reset_cnt", 32'(counter), 32'd0);
        chk("async_reset_row", 32'(read_row), 32'd0);
        step();
        rst = 1'b0;
        b = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            b += int'(busy);
        end
        chk("post_reset_idle", 32'(b), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("post_reset_start", 32'(ctl_now()), 32'b1100010);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_erase", 32'(ctl_now()), 32'd0);

        // ABORT in CONVERT at counter 100.
        start = 1'b1;
        for (int k = 0; k <= 115; k++) begin
            step();
            start = 1'b0;
        end
        chk("pre_abort_cnt", 32'(counter), 32'(code(100)));
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_ctl", 32'(ctl_now()), 32'd0);
        chk("abort_cnt", 32'(counter), 32'd0);
        f = 0;
        b = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            f += int'(frame_done);
            b += int'(busy);
        end
        chk("abort_no_done", 32'(f), 32'd0);
        chk("abort_stays_idle", 32'(b), 32'd0);

        // START and ABORT together in IDLE.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 32'(ctl_now()), 32'd0);

        // START held for 600 cycles.
        start = 1'b1;
        for (int k = 0; k < 600; k++) begin
            step();
            bz[k] = busy;
            fd[k] = frame_done;
        end
        start = 1'b0;
        chk("held_done_count", 32'($countones(fd)), 32'd2);
        chk("held_busy_272", 32'(bz[272]), 32'd1);
        chk("held_gap_273", 32'({bz[273], fd[273]}), 32'b01);
        chk("held_busy_274", 32'(bz[274]), 32'd1);
        chk("held_gap_547", 32'({bz[547], fd[547]}), 32'b01);
        chk("held_busy_548", 32'(bz[548]), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("held_abort", 32'(ctl_now()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
